// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers, used by the writeback arbiter and regfile users.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Register 0 is hard-wired: writes and reservations to it are discarded.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: NREQ requester handshakes on one side, the regfile write port on the other.
interface regfile_wb_arbiter_if #(
  parameter int width = 32,
  parameter int NREQ  = 3
);
  import regfile_pkg::*;

  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0][REG_ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][width-1:0]      req_data;
  logic [REG_ADDR_W-1:0]           W_addr;
  logic [width-1:0]                W_data;
  logic                            wr_enable;

  // Arbiter side: consumes requests, drives the regfile write port.
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, W_addr, W_data, wr_enable
  );

  // Requester / regfile side.
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, W_addr, W_data, wr_enable
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [PTR_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scan requesters in priority order starting at the pointer; first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NREQ)) begin
        sum = sum - (PTR_W+1)'(NREQ);
      end else begin
        sum = sum;
      end
      idx = sum[PTR_W-1:0];
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin sharing of the single regfile write port, plus a pending-write
// scoreboard that decode uses to detect RAW hazards.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int width = 32,
  parameter int NREQ  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_arbiter_if.slave    wb,
  input  logic                   rsv_valid,
  input  logic [REG_ADDR_W-1:0]  rsv_addr,
  input  logic                   flush,
  input  logic [REG_ADDR_W-1:0]  A_addr,
  input  logic [REG_ADDR_W-1:0]  B_addr,
  output logic                   A_pending,
  output logic                   B_pending,
  output logic [NUM_REGS-1:0]    pending
);

  localparam int PTR_W = $clog2(NREQ);

  logic [NREQ-1:0]       grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  any_req;
  logic                  xfer;
  reg_addr_t             xfer_addr;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  reg_addr_t             w_addr_q, w_addr_d;
  logic [width-1:0]      w_data_q, w_data_d;
  logic                  wr_en_q, wr_en_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i       (wb.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  // Ready is suppressed while reset is held so nothing is accepted during reset.
  assign wb.req_ready = reset ? grant : '0;
  assign xfer         = any_req & reset;
  assign xfer_addr    = wb.req_addr[grant_idx];

  assign wb.W_addr    = w_addr_q;
  assign wb.W_data    = w_data_q;
  assign wb.wr_enable = wr_en_q;
  assign pending      = pending_q;
  assign A_pending    = pending_q[A_addr];
  assign B_pending    = pending_q[B_addr];

  // Next pointer and write-port values; register-0 writes are accepted but never reach regfile.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    wr_en_d  = 1'b0;
    if (xfer) begin
      if (grant_idx == PTR_W'(NREQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + PTR_W'(1);
      end
      if (!is_zero_reg(xfer_addr)) begin
        w_addr_d = xfer_addr;
        w_data_d = wb.req_data[grant_idx];
        wr_en_d  = 1'b1;
      end else begin
        wr_en_d  = 1'b0;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Scoreboard update: completed write clears, reservation sets (set wins), flush clears all.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q) begin
      pending_d[w_addr_q] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (rsv_valid && !is_zero_reg(rsv_addr)) begin
      pending_d[rsv_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    if (flush) begin
      pending_d = '0;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; async reset also drops any write registered for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      w_addr_q  <= REG_ZERO;
      w_data_q  <= '0;
      wr_en_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      wr_en_q   <= wr_en_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: fixed vector table, hand sequences for scoreboard/reset corners,
// then randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int W = 32;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [4:0]  A_addr, B_addr;
  logic        A_pending, B_pending;
  logic [31:0] pending;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter_if #(.width(W), .NREQ(N)) wb ();

  regfile_wb_arbiter #(.width(W), .NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (wb.slave),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .A_addr    (A_addr),
    .B_addr    (B_addr),
    .A_pending (A_pending),
    .B_pending (B_pending),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [2:0]  exp_ready;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];

  // Behavioural model state.
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_pend;

  function automatic logic [31:0] dat(input int i, input logic [4:0] a);
    return 32'hD000_0000 | (32'(i) << 8) | {27'd0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    wb.req_valid   = v;
    wb.req_addr[0] = a0;
    wb.req_addr[1] = a1;
    wb.req_addr[2] = a2;
    wb.req_data[0] = dat(0, a0);
    wb.req_data[1] = dat(1, a1);
    wb.req_data[2] = dat(2, a2);
  endtask

  task automatic sb(input logic rv, input logic [4:0] ra, input logic fl);
    rsv_valid = rv;
    rsv_addr  = ra;
    flush     = fl;
  endtask

  // Round-robin choice: first valid index scanning from ptr upward, wrapping.
  function automatic int pick(input logic [2:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_cycle();
    logic [2:0]  v;
    logic [4:0]  a[3];
    logic [2:0]  exp_ready;
    logic [31:0] np;
    int          g;
    v = 3'($urandom);
    for (int i = 0; i < N; i++) begin
      a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    end
    drive(v, a[0], a[1], a[2]);
    sb(1'($urandom_range(0, 2) == 0), 5'($urandom), 1'($urandom_range(0, 15) == 0));
    A_addr = 5'($urandom);
    B_addr = 5'($urandom);
    #1;
    g = pick(v, m_ptr);
    exp_ready = (g < 0) ? 3'b000 : (3'b001 << g);
    check("rnd_ready", 64'(wb.req_ready), 64'(exp_ready));
    check("rnd_A_pending", 64'(A_pending), 64'(m_pend[A_addr]));
    check("rnd_B_pending", 64'(B_pending), 64'(m_pend[B_addr]));
    @(posedge clk);
    np = m_pend;
    if (m_wen) np[m_waddr] = 1'b0;
    if (rsv_valid && rsv_addr != 5'd0) np[rsv_addr] = 1'b1;
    if (flush) np = 32'd0;
    m_pend = np;
    m_wen = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (a[g] != 5'd0) begin
        m_wen   = 1'b1;
        m_waddr = a[g];
        m_wdata = dat(g, a[g]);
      end
    end
    #1;
    check("rnd_wen", 64'(wb.wr_enable), 64'(m_wen));
    check("rnd_pending", 64'(pending), 64'(m_pend));
    if (m_wen) begin
      check("rnd_waddr", 64'(wb.W_addr), 64'(m_waddr));
      check("rnd_wdata", 64'(wb.W_data), 64'(m_wdata));
    end
  endtask

  initial begin
    vecs[0] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, dat(0, 5'd1)};
    vecs[1] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, dat(1, 5'd2)};
    vecs[2] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, dat(2, 5'd3)};
    vecs[3] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, dat(0, 5'd1)};
    vecs[4] = '{3'b101, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, dat(2, 5'd3)};
    vecs[5] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 32'd0};
    vecs[6] = '{3'b010, 5'd1, 5'd0, 5'd3, 3'b010, 1'b0, 5'd0, 32'd0};
    vecs[7] = '{3'b011, 5'd4, 5'd6, 5'd3, 3'b001, 1'b1, 5'd4, dat(0, 5'd4)};
    vecs[8] = '{3'b011, 5'd4, 5'd6, 5'd3, 3'b010, 1'b1, 5'd6, dat(1, 5'd6)};
    vecs[9] = '{3'b110, 5'd4, 5'd6, 5'd9, 3'b100, 1'b1, 5'd9, dat(2, 5'd9)};

    // Reset held with every requester asking.
    drive(3'b111, 5'd1, 5'd2, 5'd3);
    sb(1'b0, 5'd0, 1'b0);
    A_addr = 5'd0;
    B_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(wb.req_ready), 64'd0);
    check("reset_wen", 64'(wb.wr_enable), 64'd0);
    check("reset_pending", 64'(pending), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Table: round-robin order, partial requests, idle and register-0 discard.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(wb.req_ready), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_wen", i), 64'(wb.wr_enable), 64'(vecs[i].exp_wen));
      if (vecs[i].exp_wen) begin
        check($sformatf("vec%0d_waddr", i), 64'(wb.W_addr), 64'(vecs[i].exp_waddr));
        check($sformatf("vec%0d_wdata", i), 64'(wb.W_data), 64'(vecs[i].exp_wdata));
      end
      check($sformatf("vec%0d_pending", i), 64'(pending), 64'd0);
    end

    // Scoreboard: reserve r5, then write r5 via requester 1 (pointer now 0).
    drive(3'b000, 5'd0, 5'd0, 5'd0);
    sb(1'b1, 5'd5, 1'b0);
    A_addr = 5'd5;
    B_addr = 5'd0;
    @(posedge clk);
    #1;
    check("idle_wen", 64'(wb.wr_enable), 64'd0);
    check("rsv5_pending", 64'(pending), 64'h20);
    check("rsv5_A_pending", 64'(A_pending), 64'd1);
    check("rsv5_B_pending", 64'(B_pending), 64'd0);
    sb(1'b0, 5'd0, 1'b0);
    drive(3'b010, 5'd0, 5'd5, 5'd0);
    #1;
    check("wr5_ready", 64'(wb.req_ready), 64'b010);
    @(posedge clk);
    #1;
    check("wr5_wen", 64'(wb.wr_enable), 64'd1);
    check("wr5_waddr", 64'(wb.W_addr), 64'd5);
    check("wr5_wdata", 64'(wb.W_data), 64'(dat(1, 5'd5)));
    check("wr5_still_pending", 64'(pending), 64'h20);
    drive(3'b000, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    check("wr5_cleared", 64'(pending), 64'd0);
    check("wr5_A_cleared", 64'(A_pending), 64'd0);

    // Collision: reserve r7 again in the very cycle its write is on the port (pointer now 2).
    sb(1'b1, 5'd7, 1'b0);
    drive(3'b100, 5'd0, 5'd0, 5'd7);
    #1;
    check("wr7_ready", 64'(wb.req_ready), 64'b100);
    @(posedge clk);
    #1;
    drive(3'b000, 5'd0, 5'd0, 5'd0);
    check("wr7_wen", 64'(wb.wr_enable), 64'd1);
    check("wr7_waddr", 64'(wb.W_addr), 64'd7);
    @(posedge clk);
    #1;
    check("collision_pending", 64'(pending), 64'h80);
    sb(1'b1, 5'd9, 1'b1);
    @(posedge clk);
    #1;
    check("flush_pending", 64'(pending), 64'd0);
    sb(1'b1, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    check("rsv_zero_pending", 64'(pending), 64'd0);
    sb(1'b0, 5'd0, 1'b0);

    // Async reset dropped between edges while a write is on the port (pointer now 0).
    drive(3'b111, 5'd1, 5'd2, 5'd3);
    @(posedge clk);
    #1;
    check("burst_wen", 64'(wb.wr_enable), 64'd1);
    check("burst_waddr", 64'(wb.W_addr), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_wen", 64'(wb.wr_enable), 64'd0);
    check("arst_waddr", 64'(wb.W_addr), 64'd0);
    check("arst_ready", 64'(wb.req_ready), 64'd0);
    #1 reset = 1'b1;
    #1;
    check("arst_ptr", 64'(wb.req_ready), 64'b001);

    // Randomized traffic from a quiet, freshly reset state.
    drive(3'b000, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    m_ptr   = 0;
    m_wen   = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 32'd0;
    m_pend  = 32'd0;
    for (int c = 0; c < 500; c++) begin
      rand_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
